// File: rtl/alu_pkg.sv
// Shared definitions for the serial add/subtract ALU: FSM state encoding and
// the datapath slice width processed per RUN cycle.
package alu_pkg;

  // Width of one datapath slice; the serial ALU consumes one nibble per cycle.
  localparam int NIBBLE_W = 4;

  // Control FSM states of the serial ALU.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/cla_4bit.sv
// 4-bit carry-lookahead adder: the nibble datapath of the serial ALU.
// Carries are written as fully expanded generate/propagate terms so no carry
// ripples through the slice.
module cla_4bit
  import alu_pkg::*;
(
  input  logic [NIBBLE_W-1:0] i_a,
  input  logic [NIBBLE_W-1:0] i_b,
  input  logic                i_c,
  output logic [NIBBLE_W-1:0] o_sum,
  output logic                o_c
);

  logic [3:0] g_s;
  logic [3:0] p_s;
  logic [4:0] c_s;

  // Generate/propagate terms, lookahead carries and the nibble sum.
  always_comb begin
    g_s    = i_a & i_b;
    p_s    = i_a ^ i_b;
    c_s[0] = i_c;
    c_s[1] = g_s[0] | (p_s[0] & i_c);
    c_s[2] = g_s[1] | (p_s[1] & g_s[0]) | (p_s[1] & p_s[0] & i_c);
    c_s[3] = g_s[2] | (p_s[2] & g_s[1]) | (p_s[2] & p_s[1] & g_s[0])
           | (p_s[2] & p_s[1] & p_s[0] & i_c);
    c_s[4] = g_s[3] | (p_s[3] & g_s[2]) | (p_s[3] & p_s[2] & g_s[1])
           | (p_s[3] & p_s[2] & p_s[1] & g_s[0])
           | (p_s[3] & p_s[2] & p_s[1] & p_s[0] & i_c);
    o_sum  = p_s ^ c_s[3:0];
    o_c    = c_s[4];
  end

endmodule

// File: rtl/alu_serial_addsub.sv
// Nibble-serial adder/subtractor with valid/ready handshakes on both sides.
// A request accepted in IDLE is processed one nibble per cycle (LSB first)
// through a single cla_4bit; the result is held in DONE until writeback takes
// it. Subtraction is A + ~B + 1 (carry register preset to 1).
// Optional build macro: ALU_SERIAL_FLAGS_EN enables the signed-overflow and
// zero flags; without it both flags are tied low and the MSB capture flops
// are not built.
module alu_serial_addsub
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  input  logic            i_sub,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_result,
  output logic            o_carry,
  output logic            o_overflow,
  output logic            o_zero
);

  localparam int NIB_CNT = XLEN / NIBBLE_W;
  localparam int CNT_W   = $clog2(NIB_CNT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NIB_CNT - 1);

  state_e            state_q, state_d;
  logic [XLEN-1:0]   a_q, a_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic [XLEN-1:0]   res_q, res_d;
  logic              carry_q, carry_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [NIBBLE_W-1:0] nib_sum_s;
  logic                nib_co_s;
  logic                last_nib_s;

  assign last_nib_s = (cnt_q == CNT_LAST);

  cla_4bit u_cla (
    .i_a   (a_q[NIBBLE_W-1:0]),
    .i_b   (b_q[NIBBLE_W-1:0]),
    .i_c   (carry_q),
    .o_sum (nib_sum_s),
    .o_c   (nib_co_s)
  );

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: accept in IDLE, count nibbles in RUN, handshake out of DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (i_valid) state_d = ST_RUN;
        else         state_d = ST_IDLE;
      end
      ST_RUN: begin
        if (last_nib_s) state_d = ST_DONE;
        else            state_d = ST_RUN;
      end
      ST_DONE: begin
        if (i_ready) state_d = ST_IDLE;
        else         state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode: handshake flags depend only on the registered state.
  always_comb begin
    o_ready = 1'b0;
    o_valid = 1'b0;
    case (state_q)
      ST_IDLE: o_ready = 1'b1;
      ST_RUN:  o_ready = 1'b0;
      ST_DONE: o_valid = 1'b1;
      default: begin
        o_ready = 1'b0;
        o_valid = 1'b0;
      end
    endcase
  end

  // Datapath next values: load operands on accept, shift one nibble per RUN cycle.
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (i_valid) begin
          a_d     = i_a;
          b_d     = i_sub ? ~i_b : i_b;
          carry_d = i_sub;
          cnt_d   = '0;
        end else begin
          a_d     = a_q;
        end
      end
      ST_RUN: begin
        a_d     = {{NIBBLE_W{1'b0}}, a_q[XLEN-1:NIBBLE_W]};
        b_d     = {{NIBBLE_W{1'b0}}, b_q[XLEN-1:NIBBLE_W]};
        res_d   = {nib_sum_s, res_q[XLEN-1:NIBBLE_W]};
        carry_d = nib_co_s;
        // Counter saturates on the last nibble; the FSM leaves RUN there.
        if (last_nib_s) cnt_d = cnt_q;
        else            cnt_d = cnt_q + CNT_W'(1);
      end
      ST_DONE: begin
        res_d = res_q;
      end
      default: begin
        res_d = res_q;
      end
    endcase
  end

  // Datapath registers; reset clears everything so no stale result survives.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_result = res_q;
  assign o_carry  = carry_q;

`ifdef ALU_SERIAL_FLAGS_EN
  logic a_msb_q, a_msb_d;
  logic b_msb_q, b_msb_d;
  logic ovf_q, ovf_d;
  logic zero_q, zero_d;

  // Flag next values: capture operand MSBs on accept, resolve flags on the last nibble.
  always_comb begin
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    case (state_q)
      ST_IDLE: begin
        if (i_valid) begin
          a_msb_d = i_a[XLEN-1];
          b_msb_d = i_sub ? ~i_b[XLEN-1] : i_b[XLEN-1];
          ovf_d   = 1'b0;
          zero_d  = 1'b0;
        end else begin
          a_msb_d = a_msb_q;
        end
      end
      ST_RUN: begin
        if (last_nib_s) begin
          // The last nibble's top bit is the result MSB.
          ovf_d  = (a_msb_q == b_msb_q) && (nib_sum_s[NIBBLE_W-1] != a_msb_q);
          zero_d = (res_d == '0);
        end else begin
          ovf_d  = ovf_q;
        end
      end
      ST_DONE: ovf_d = ovf_q;
      default: ovf_d = ovf_q;
    endcase
  end

  // Flag registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign o_overflow = ovf_q;
  assign o_zero     = zero_q;
`else
  assign o_overflow = 1'b0;
  assign o_zero     = 1'b0;
`endif

endmodule

// File: doc/alu_serial_addsub.md
ALU_SERIAL_ADDSUB -- requirements
Module: alu_serial_addsub

Interface
REQ-001 SHALL have parameter: XLEN, 32, operand/result width in bits; multiple of 4, minimum 8.
REQ-002 SHALL have port: i_clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port: i_rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: i_valid  input  1  request valid from issue stage.
REQ-005 SHALL have port: o_ready  output  1  block can accept a request.
REQ-006 SHALL have port: i_a  input  XLEN  operand A.
REQ-007 SHALL have port: i_b  input  XLEN  operand B.
REQ-008 SHALL have port: i_sub  input  1  1 = A-B, 0 = A+B.
REQ-009 SHALL have port: o_valid  output  1  result valid to writeback.
REQ-010 SHALL have port: i_ready  input  1  writeback accepts result.
REQ-011 SHALL have port: o_result  output  XLEN  sum/difference.
REQ-012 SHALL have port: o_carry  output  1  carry out of bit XLEN-1 (for sub: 1 = no borrow).
REQ-013 SHALL have ports: o_overflow  output  1  signed overflow, and o_zero  output  1  result is zero.

Function
REQ-014 SHALL implement three states: IDLE, RUN, DONE.
REQ-015 SHALL drive o_ready=1 only in IDLE and o_valid=1 only in DONE.
REQ-016 In IDLE, i_valid=1 SHALL accept the request: latch i_a, latch B' = i_sub ? ~i_b : i_b, set carry register to i_sub, clear nibble counter, go to RUN.
REQ-017 In RUN, each cycle SHALL add one 4-bit nibble, LSB nibble first. The nibble input is A/B' bits [3:0] plus the carry register. Shift A and B' right by 4. Shift the 4-bit sum into o_result from the top. Store the nibble carry-out in the carry register.
REQ-018 After XLEN/4 RUN cycles SHALL enter DONE. o_valid rises exactly XLEN/4 cycles after the accept edge (8 for XLEN=32).
REQ-019 In DONE, o_result/o_carry/o_overflow/o_zero SHALL stay stable until i_valid... i_ready=1. On o_valid&&i_ready the block SHALL go to IDLE (o_ready=1 next cycle).
REQ-020 i_valid, i_a, i_b and i_sub SHALL be ignored outside IDLE. No abort path exists.
REQ-021 Arithmetic SHALL be modulo 2^XLEN. o_carry is the final nibble carry-out.
REQ-022 Nibble counter SHALL be $clog2(XLEN/4) bits wide and SHALL not wrap within an operation.

Reset
REQ-023 Asserting i_rst_n=0 in any state, including mid-RUN, SHALL immediately force IDLE. It SHALL also clear every register: o_ready=1, o_valid=0, o_result=0, o_carry=0, o_overflow=0, o_zero=0.
REQ-024 No partial result SHALL be presented after reset. The first request after deassertion SHALL complete normally.

Configuration
REQ-025 Macro ALU_SERIAL_FLAGS_EN SHALL gate flag logic.
- Defined: o_overflow = (A[XLEN-1]==B'[XLEN-1]) && (o_result[XLEN-1]!=A[XLEN-1]), using operand MSBs captured at accept. o_zero = (o_result==0). Both are valid in DONE.
- Undefined: o_overflow and o_zero tied 0, MSB capture registers removed.

Structure
REQ-026 Package alu_pkg SHALL hold the state encoding typedef (IDLE/RUN/DONE) and the NIBBLE_W=4 constant.
REQ-027 SHALL instantiate exactly one cla_4bit as its nibble datapath sub-module. No other adder is permitted.

Verification
REQ-028 Add 0x00000001+0xFFFFFFFF -> o_result=0x00000000, o_carry=1, o_zero=1, o_overflow=0; o_valid exactly 8 cycles after accept.
REQ-029 Sub 0x00000005-0x00000007 -> o_result=0xFFFFFFFE, o_carry=0, o_overflow=0, o_zero=0.
REQ-030 Add 0x7FFFFFFF+0x00000001 -> o_result=0x80000000, o_overflow=1, o_carry=0. Sub 0x80000000-0x00000001 -> 0x7FFFFFFF, o_overflow=1.
REQ-031 Hold i_ready=0 for 5 cycles in DONE with i_valid=1 and new operands -> outputs unchanged, o_ready=0, new request not taken until the cycle after the i_ready handshake.
REQ-032 Assert i_rst_n=0 during the 3rd RUN cycle -> o_valid=0, o_ready=1, o_result=0 immediately. After deassertion, add 0x12345678+0x11111111 -> 0x23456789.
REQ-033 Build without ALU_SERIAL_FLAGS_EN and rerun REQ-028 -> o_zero=0, o_overflow=0, o_result and o_carry unchanged.
